led_fader: RTL and testbench
============================

LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter PWM_BITS, default 8: PWM/brightness resolution; MAX = 2^PWM_BITS-1.
REQ-002 Parameter FADE_DIV, default 19_531: clk cycles per brightness step (full ramp ≈ 0.1 s at 50 MHz).
REQ-003 Port clk  input  1: system clock, 50 MHz, rising edge.
REQ-004 Port nrst  input  1: reset, asynchronous, active-low.
REQ-005 Port led_in  input  4: target LED pattern from the upstream LED sequencer, synchronous to clk, any value (not restricted to one-hot).
REQ-006 Port enable  input  1: 1 = follow led_in; 0 = effective target 4'b0000.
REQ-007 Port led_out  output  4: PWM drive to board LEDs, active-high.
REQ-008 Port busy  output  1: 1 while any channel is in RISE or FALL.

Function
REQ-009 led_in and enable SHALL be registered once; effective target tgt[i] = led_in_q[i] & enable_q.
REQ-010 PWM counter pwm_cnt SHALL count 0..MAX-1 and wrap to 0, giving a period of MAX cycles.
REQ-011 led_out[i] SHALL be registered, = (duty[i] > pwm_cnt); duty 0 -> never high; duty MAX -> always high; duty d -> exactly d high cycles per period.
REQ-012 Prescaler SHALL count 0..FADE_DIV-1, free-running, and assert one-cycle tick when at FADE_DIV-1.
REQ-013 Each channel i SHALL have an independent FSM {OFF, RISE, ON, FALL} plus a PWM_BITS-wide duty[i].
REQ-014 OFF: duty=0; tgt=1 -> RISE.
REQ-015 RISE: on tick, duty+1; duty reaching MAX -> ON; tgt=0 -> FALL, keeping current duty (no jump).
REQ-016 ON: duty=MAX; tgt=0 -> FALL.
REQ-017 FALL: on tick, duty-1; duty reaching 0 -> OFF; tgt=1 -> RISE, keeping current duty.
REQ-018 Duty SHALL saturate at 0 and MAX; never wrap.
REQ-019 When a tick and a target change occur in the same cycle, the state change SHALL take effect and the step SHALL be applied in the new direction.
REQ-020 Latency: led_in edge -> FSM state change 2 cycles; first duty step at the next tick after that.
REQ-021 Full ramp 0 -> MAX SHALL take MAX ticks (MAX*FADE_DIV cycles ±FADE_DIV).
REQ-022 busy SHALL be registered, = OR over channels of (state in RISE or FALL).
REQ-023 Multiple channels SHALL fade concurrently and independently (e.g. chaser handoff: one falls while the next rises).

Reset
REQ-024 nrst low SHALL asynchronously clear led_in_q, enable_q, pwm_cnt, prescaler, every duty to 0, every FSM to OFF, led_out=4'b0000, busy=0.
REQ-025 Reset asserted mid-fade SHALL zero outputs immediately; after release, operation SHALL restart from OFF with no memory of prior duty.

Verification (PWM_BITS=4, MAX=15, FADE_DIV=4)
REQ-026 Reset held, led_in=4'b1111, enable=1 -> led_out=0000, busy=0; after release, led_out[i] is first high no earlier than the first tick.
REQ-027 led_in=0001 held -> duty[0] +1 every 4 cycles, reaches 15 after 60 cycles (±4); led_out[0] then constantly high; busy 1 during ramp, 0 after.
REQ-028 Per-period high count on led_out[0] during ramp -> equals duty, non-decreasing; led_out[3:1] stay 0 throughout.
REQ-029 led_in 0001 -> 0000 when duty[0]=7 -> duty decreases 7,6,...,0 (no jump to 15 or 0); FSM ends in OFF; busy drops.
REQ-030 Channels 0 and 1 at ON/OFF, led_in 0001 -> 0010 -> ch0 falls and ch1 rises concurrently; at each tick duty[0]+duty[1]=15; busy=1 until both settle.
REQ-031 All channels ON, enable -> 0 -> all four fade to 0 in 60 cycles (±4); led_out=0000; then reset asserted mid-ramp on re-enable -> led_out=0000 immediately.

Source files
------------

// File: rtl/led_fader.sv
// Four-channel LED fader: each channel ramps its PWM duty toward the registered target
// pattern, one step per prescaler tick, with an independent OFF/RISE/ON/FALL FSM.
module led_fader #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned FADE_DIV = 19_531
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [3:0] led_in,
    input  logic       enable,
    output logic [3:0] led_out,
    output logic       busy
);

    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam int unsigned         PW       = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PW-1:0]       PRE_LAST = PW'(FADE_DIV - 1);

    typedef enum logic [1:0] {OFF, RISE, ON, FALL} state_e;

    logic [3:0]          led_in_q;
    logic                enable_q;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                tick;
    logic [3:0]          tgt;
    state_e              state_q [4];
    state_e              state_d [4];
    logic [PWM_BITS-1:0] duty_q [4];
    logic [PWM_BITS-1:0] duty_d [4];
    logic [3:0]          led_out_q, led_out_d;
    logic                busy_q, busy_d;

    assign tgt  = led_in_q & {4{enable_q}};
    assign tick = (presc_q == PRE_LAST);

    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
        presc_d   = tick ? '0 : presc_q + 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            led_out_d[i] = (duty_q[i] > pwm_cnt_q);
        end
    end

    // Direction is resolved first so a tick coinciding with a target change steps the new way;
    // the end-of-ramp check then runs on the stepped duty.
    always_comb begin
        busy_d = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            duty_d[i]  = duty_q[i];
            case (state_q[i])
                OFF:  if (tgt[i])  state_d[i] = RISE;
                RISE: if (!tgt[i]) state_d[i] = FALL;
                ON:   if (!tgt[i]) state_d[i] = FALL;
                FALL: if (tgt[i])  state_d[i] = RISE;
            endcase
            if (tick) begin
                if (state_d[i] == RISE && duty_q[i] != MAX) begin
                    duty_d[i] = duty_q[i] + 1'b1;
                end else if (state_d[i] == FALL && duty_q[i] != '0) begin
                    duty_d[i] = duty_q[i] - 1'b1;
                end
            end
            if (state_d[i] == RISE && duty_d[i] == MAX) begin
                state_d[i] = ON;
            end else if (state_d[i] == FALL && duty_d[i] == '0) begin
                state_d[i] = OFF;
            end
            if (state_d[i] == RISE || state_d[i] == FALL) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            led_in_q  <= '0;
            enable_q  <= 1'b0;
            pwm_cnt_q <= '0;
            presc_q   <= '0;
            led_out_q <= '0;
            busy_q    <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= OFF;
                duty_q[i]  <= '0;
            end
        end else begin
            led_in_q  <= led_in;
            enable_q  <= enable;
            pwm_cnt_q <= pwm_cnt_d;
            presc_q   <= presc_d;
            led_out_q <= led_out_d;
            busy_q    <= busy_d;
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                duty_q[i]  <= duty_d[i];
            end
        end
    end

    assign led_out = led_out_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// Directed + randomized bench for led_fader; the reference model moves each channel's duty
// one unit toward its target level per tick.
module tb_led_fader;

    localparam int PB = 4;
    localparam int FD = 4;
    localparam int MX = 15;

    logic       clk = 1'b0;
    logic       nrst;
    logic [3:0] led_in;
    logic       enable;
    logic [3:0] led_out;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    int m_lin, m_en, m_pwm, m_presc, m_led, m_busy;
    int m_duty [4];

    led_fader #(.PWM_BITS(PB), .FADE_DIV(FD)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .led_in  (led_in),
        .enable  (enable),
        .led_out (led_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_lin = 0; m_en = 0; m_pwm = 0; m_presc = 0; m_led = 0; m_busy = 0;
        for (int i = 0; i < 4; i++) m_duty[i] = 0;
    endtask

    // One clock edge of the fader seen from outside: brightness creeps toward its goal.
    task automatic model_edge();
        int goal;
        bit tick;
        tick   = (m_presc == FD - 1);
        m_led  = 0;
        m_busy = 0;
        for (int i = 0; i < 4; i++) begin
            goal = (((m_lin >> i) & 1) != 0 && m_en != 0) ? MX : 0;
            if (m_duty[i] > m_pwm) m_led |= (1 << i);
            if (tick) begin
                if (m_duty[i] < goal) m_duty[i]++;
                else if (m_duty[i] > goal) m_duty[i]--;
            end
            if (m_duty[i] != goal) m_busy = 1;
        end
        m_pwm   = (m_pwm == MX - 1) ? 0 : m_pwm + 1;
        m_presc = (m_presc == FD - 1) ? 0 : m_presc + 1;
        m_lin   = int'(led_in);
        m_en    = int'(enable);
    endtask

    task automatic compare();
        chk("led_out", 32'(led_out), m_led);
        chk("busy", 32'(busy), m_busy);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("duty%0d", i), 32'(dut.duty_q[i]), m_duty[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (nrst) model_edge();
        else model_reset();
        #1;
        compare();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic mid_reset();
        #2;
        nrst = 1'b0;
        model_reset();
        #1;
        chk("rst_led_out", 32'(led_out), 0);
        chk("rst_busy", 32'(busy), 0);
    endtask

    initial begin
        // Reset held with all targets requested
        nrst = 1'b0; led_in = 4'b1111; enable = 1'b1;
        model_reset();
        #1;
        chk("por_led_out", 32'(led_out), 0);
        chk("por_busy", 32'(busy), 0);
        run(3);
        nrst = 1'b1;
        run(80);

        // Settle to dark, then single-channel ramp up
        led_in = 4'b0000;
        run(80);
        chk("dark_busy", 32'(busy), 0);
        led_in = 4'b0001;
        run(80);
        chk("ramp_full", 32'(dut.duty_q[0]), MX);
        chk("ramp_busy", 32'(busy), 0);

        // Reverse mid-ramp at duty 7
        led_in = 4'b0000;
        run(80);
        led_in = 4'b0001;
        for (int k = 0; k < 200 && m_duty[0] != 7; k++) step();
        chk("reach7", 32'(dut.duty_q[0]), 7);
        led_in = 4'b0000;
        run(80);
        chk("fall_done", 32'(dut.duty_q[0]), 0);
        chk("fall_busy", 32'(busy), 0);

        // Chaser handoff: ch0 falls while ch1 rises
        led_in = 4'b0001;
        run(80);
        led_in = 4'b0010;
        for (int k = 0; k < 80; k++) begin
            step();
            chk("handoff_sum", 32'(dut.duty_q[0]) + 32'(dut.duty_q[1]), MX);
        end
        chk("handoff_busy", 32'(busy), 0);

        // All on, global disable, then reset during re-enable ramp
        led_in = 4'b1111;
        run(80);
        enable = 1'b0;
        run(70);
        chk("disable_led_out", 32'(led_out), 0);
        enable = 1'b1;
        run(22);
        mid_reset();
        run(3);
        nrst = 1'b1;
        run(40);

        // Random target traffic with occasional resets
        for (int k = 0; k < 1200; k++) begin
            if ($urandom_range(15) == 0) led_in = 4'($urandom);
            if ($urandom_range(40) == 0) enable = ~enable;
            if ($urandom_range(400) == 0) begin
                mid_reset();
                run(2);
                nrst = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
